// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory responding to the multicycle core
// with a pulse request / pulse ready handshake, programmable wait states and byte-lane writes.
module mem_responder #(
  parameter int    DEPTH_LOG2  = 6,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req,
  input  logic        WE,
  input  logic [31:0] Addr,
  input  logic [3:0]  ByteEn,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Ready,
  output logic        Err,
  output logic [31:0] RData
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem [2**DEPTH_LOG2];
  logic                  sel_in, go, a_we, mis;
  logic [DEPTH_LOG2+1:0] a_addr;
  logic [3:0]            a_be;
  logic [31:0]           a_wdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_addr;
  assign unused_addr = ^Addr[31:DEPTH_LOG2+2];
  // With zero wait states the access happens on the accept edge, straight from the inputs
  assign sel_in  = state == IDLE;
  assign go      = (sel_in && Req && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd1);
  assign a_we    = sel_in ? WE : we_q;
  assign a_addr  = sel_in ? Addr[DEPTH_LOG2+1:0] : addr_q;
  assign a_be    = sel_in ? ByteEn : be_q;
  assign a_wdata = sel_in ? WData : wdata_q;
  assign idx     = a_addr[DEPTH_LOG2+1:2];
  assign mis     = |a_addr[1:0];
  always_ff @(posedge Clk) begin
    if (go && a_we && !mis)
      for (int i = 0; i < 4; i++)
        if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      Busy    <= 1'b0;
      Ready   <= 1'b0;
      Err     <= 1'b0;
      RData   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      Ready <= go;
      Err   <= go && mis;
      if (go && !a_we && !mis) RData <= mem[idx];
      case (state)
        IDLE: if (Req) begin
          we_q    <= WE;
          addr_q  <= Addr[DEPTH_LOG2+1:0];
          be_q    <= ByteEn;
          wdata_q <= WData;
          cnt     <= 4'(WAIT_STATES);
          state   <= WAIT_STATES == 0 ? RESP : WAIT;
          Busy    <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder; expectations come from a word-array model.
module tb_mem_responder;
  localparam int WS = 2;
  localparam int DL = 6;
  typedef struct packed {logic err; logic [31:0] rd;} exp_t;
  logic        Clk = 1'b0, Reset_n = 1'b0, Req = 1'b0, WE = 1'b0;
  logic [31:0] Addr = '0, WData = '0;
  logic [3:0]  ByteEn = '0;
  logic        Busy, Ready, Err;
  logic [31:0] RData;
  int          checks = 0, failures = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] model [2**DL];
  logic [31:0] last_rd = '0;

  mem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .WE(WE), .Addr(Addr), .ByteEn(ByteEn),
    .WData(WData), .Busy(Busy), .Ready(Ready), .Err(Err), .RData(RData)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Ready) begin
      if (sb.size() == 0) check("unexpected_ready", {31'b0, Ready}, 32'd0);
      else begin
        e = sb.pop_front();
        check("err", {31'b0, Err}, {31'b0, e.err});
        check("rdata", RData, e.rd);
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic poke);
    logic          mis;
    logic [DL-1:0] idx;
    int            n;
    mis = |a[1:0];
    idx = a[DL+1:2];
    if (!mis && !we) last_rd = model[idx];
    sb.push_back({mis, last_rd});
    if (!mis && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
    @(negedge Clk);
    Req = 1'b1; WE = we; Addr = a; ByteEn = be; WData = wd;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 1) begin
        check("busy", {31'b0, Busy}, 32'd1);
        Req = poke;
      end else Req = 1'b0;
    end while (!Ready && n < 20);
    check("latency", n, WS + 1);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_ready", {31'b0, Ready}, 32'd0);
    check("rst_rdata", RData, 32'd0);
    Reset_n = 1'b1;
    access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    access(1'b1, 32'h10, 4'h1, 32'h000000AA, 1'b0);
    access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    access(1'b1, 32'h12, 4'hF, 32'h0, 1'b0);
    access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    access(1'b0, 32'h11, 4'h0, 32'h0, 1'b0);
    access(1'b1, 32'h100, 4'hF, 32'h12345678, 1'b1);
    access(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    access(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 1'b0);
    access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    access(1'b1, 32'hFFFFFF04, 4'hC, 32'hCAFEF00D, 1'b0);
    access(1'b1, 32'h4, 4'h3, 32'h1111F00D, 1'b0);
    access(1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
    access(1'b1, 32'h20, 4'hF, 32'h0BADF00D, 1'b0);
    access(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    @(negedge Clk);
    Req = 1'b1; WE = 1'b1; Addr = 32'h20; ByteEn = 4'hF; WData = 32'h55555555;
    @(negedge Clk);
    Req = 1'b0;
    check("wait_busy", {31'b0, Busy}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, Busy}, 32'd0);
    check("arst_ready", {31'b0, Ready}, 32'd0);
    check("arst_err", {31'b0, Err}, 32'd0);
    check("arst_rdata", RData, 32'd0);
    last_rd = '0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    check("post_rst_busy", {31'b0, Busy}, 32'd0);
    access(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    repeat (6) @(negedge Clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
